// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arbiter
//  Purpose  : Shares one 32Kx8 SRAM port between the CPU bus and the serial
//             program loader. One access at a time; waits out the SRAM read
//             latency and returns registered data with a one-cycle ack.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 2,
    parameter int CPU_PRIO = 1
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    // CPU port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    // Loader port
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_ack,
    // SRAM macro
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    // Status
    output logic              busy,
    output logic              gnt_ld
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    // WAIT runs until the counter hits zero, so RD_LAT=1 gives one WAIT cycle.
    localparam logic [2:0] c_LAT_INIT = 3'(RD_LAT - 1);

    logic [1:0]        r_state;
    logic [2:0]        r_cnt;
    logic              r_gnt_ld;
    logic              r_sram_cs;
    logic              r_sram_we;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_sram_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_ld_rdata;
    logic              r_cpu_ack;
    logic              r_ld_ack;
    logic              r_busy;

    logic              w_any_req;
    logic              w_rr_mode;
    logic              w_pick_ld;

    // Loader wins when alone, or on a round-robin tie when the CPU went last.
    always_comb begin
        w_any_req = cpu_req | ld_req;
        w_rr_mode = (CPU_PRIO == 0);
        w_pick_ld = ld_req & (~cpu_req | (w_rr_mode & ~r_gnt_ld));
    end

    // Access sequencer: arbitrate, issue one SRAM cycle, wait latency, ack.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= c_IDLE;
            r_cnt        <= 3'd0;
            r_gnt_ld     <= 1'b1;
            r_sram_cs    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_cpu_rdata  <= '0;
            r_ld_rdata   <= '0;
            r_cpu_ack    <= 1'b0;
            r_ld_ack     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_state      <= c_ACCESS;
                        r_busy       <= 1'b1;
                        r_gnt_ld     <= w_pick_ld;
                        r_sram_cs    <= 1'b1;
                        r_sram_we    <= w_pick_ld ? ld_we    : cpu_we;
                        r_sram_addr  <= w_pick_ld ? ld_addr  : cpu_addr;
                        r_sram_wdata <= w_pick_ld ? ld_wdata : cpu_wdata;
                    end
                end
                c_ACCESS: begin
                    // The registered we doubles as the write/read decision.
                    r_sram_cs <= 1'b0;
                    r_sram_we <= 1'b0;
                    if (r_sram_we) begin
                        r_state   <= c_DONE;
                        r_ld_ack  <= r_gnt_ld;
                        r_cpu_ack <= ~r_gnt_ld;
                    end else begin
                        r_state <= c_WAIT;
                        r_cnt   <= c_LAT_INIT;
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= c_DONE;
                        if (r_gnt_ld) begin
                            r_ld_rdata <= sram_rdata;
                            r_ld_ack   <= 1'b1;
                        end else begin
                            r_cpu_rdata <= sram_rdata;
                            r_cpu_ack   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                c_DONE: begin
                    r_state   <= c_IDLE;
                    r_cpu_ack <= 1'b0;
                    r_ld_ack  <= 1'b0;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_ack    = r_cpu_ack;
    assign ld_rdata   = r_ld_rdata;
    assign ld_ack     = r_ld_ack;
    assign sram_cs    = r_sram_cs;
    assign sram_we    = r_sram_we;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;
    assign busy       = r_busy;
    assign gnt_ld     = r_gnt_ld;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_arbiter
//  Purpose  : Scoreboard bench for sram_arbiter. Four instances cover
//             fixed priority / round-robin and RD_LAT = 1, 2, 7, each backed
//             by a behavioural SRAM with the matching read latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int NI = 4;

    // Instance 0: RD_LAT=2 fixed prio, 1: RD_LAT=2 round-robin,
    // 2: RD_LAT=1 fixed prio, 3: RD_LAT=7 fixed prio.
    function automatic int lat_of(input int i);
        case (i)
            2:       return 1;
            3:       return 7;
            default: return 2;
        endcase
    endfunction

    function automatic int prio_of(input int i);
        return (i == 1) ? 0 : 1;
    endfunction

    logic clk = 1'b0;
    logic sys_rst_n;
    int   cyc = 0;

    logic [NI-1:0]       cpu_req, cpu_we, ld_req, ld_we;
    logic [NI-1:0][14:0] cpu_addr, ld_addr;
    logic [NI-1:0][7:0]  cpu_wdata, ld_wdata;
    wire  [NI-1:0][7:0]  cpu_rdata, ld_rdata, sram_wdata, sram_rdata;
    wire  [NI-1:0][14:0] sram_addr;
    wire  [NI-1:0]       cpu_ack, ld_ack, sram_cs, sram_we, busy, gnt_ld;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        sram_arbiter #(
            .ADDR_W  (15),
            .DATA_W  (8),
            .RD_LAT  (lat_of(gi)),
            .CPU_PRIO(prio_of(gi))
        ) u_dut (
            .clk       (clk),
            .sys_rst_n (sys_rst_n),
            .cpu_req   (cpu_req[gi]),
            .cpu_we    (cpu_we[gi]),
            .cpu_addr  (cpu_addr[gi]),
            .cpu_wdata (cpu_wdata[gi]),
            .cpu_rdata (cpu_rdata[gi]),
            .cpu_ack   (cpu_ack[gi]),
            .ld_req    (ld_req[gi]),
            .ld_we     (ld_we[gi]),
            .ld_addr   (ld_addr[gi]),
            .ld_wdata  (ld_wdata[gi]),
            .ld_rdata  (ld_rdata[gi]),
            .ld_ack    (ld_ack[gi]),
            .sram_cs   (sram_cs[gi]),
            .sram_we   (sram_we[gi]),
            .sram_addr (sram_addr[gi]),
            .sram_wdata(sram_wdata[gi]),
            .sram_rdata(sram_rdata[gi]),
            .busy      (busy[gi]),
            .gnt_ld    (gnt_ld[gi])
        );

        // SRAM model: data read in the cs cycle appears RD_LAT-1 edges later;
        // outside a read the pipe carries filler so early/late capture shows.
        logic [7:0] mem  [0:32767];
        logic [7:0] pipe [0:7];
        always @(posedge clk) begin
            if (sram_cs[gi] && sram_we[gi]) mem[sram_addr[gi]] <= sram_wdata[gi];
            pipe[0] <= (sram_cs[gi] && !sram_we[gi]) ? mem[sram_addr[gi]] : 8'hEE;
            for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
        end
        assign sram_rdata[gi] = pipe[lat_of(gi) - 1];
    end

    typedef struct {
        int         inst;
        bit         ld;
        bit         rd;
        logic [7:0] data;
        int         cyc;
    } ack_t;

    typedef struct {
        int          inst;
        bit          we;
        logic [14:0] addr;
        logic [7:0]  wdata;
        int          cyc;
    } acc_t;

    ack_t ack_q[$];
    acc_t acc_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cycle=%0d: got %0h expected %0h", nm, inst, cyc, act, exp);
        end
    endtask

    task automatic exp_acc(input int inst, input bit we, input logic [14:0] addr,
                           input logic [7:0] wd, input int c);
        acc_t a;
        a.inst = inst; a.we = we; a.addr = addr; a.wdata = wd; a.cyc = c;
        acc_q.push_back(a);
    endtask

    task automatic exp_ack(input int inst, input bit ld, input bit rd,
                           input logic [7:0] d, input int c);
        ack_t e;
        e.inst = inst; e.ld = ld; e.rd = rd; e.data = d; e.cyc = c;
        ack_q.push_back(e);
    endtask

    // Present a request and hold it until the matching ack is seen.
    task automatic drive(input int inst, input bit ld, input bit we,
                         input logic [14:0] addr, input logic [7:0] wd);
        int n;
        bit got;
        if (ld) begin
            ld_req[inst] = 1'b1; ld_we[inst] = we; ld_addr[inst] = addr; ld_wdata[inst] = wd;
        end else begin
            cpu_req[inst] = 1'b1; cpu_we[inst] = we; cpu_addr[inst] = addr; cpu_wdata[inst] = wd;
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = ld ? ld_ack[inst] : cpu_ack[inst];
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout inst=%0d ld=%0d: got no ack expected ack within 40 cycles", inst, ld);
        end
    endtask

    task automatic rel(input int inst, input bit ld);
        if (ld) ld_req[inst] = 1'b0;
        else    cpu_req[inst] = 1'b0;
    endtask

    // Isolated transaction from an idle arbiter.
    task automatic txn(input int inst, input bit ld, input bit we, input logic [14:0] addr,
                       input logic [7:0] wd, input logic [7:0] rd_exp);
        int s;
        @(negedge clk);
        s = cyc;
        exp_acc(inst, we, addr, wd, s + 1);
        exp_ack(inst, ld, !we, rd_exp, s + 2 + (we ? 0 : lat_of(inst)));
        drive(inst, ld, we, addr, wd);
        rel(inst, ld);
    endtask

    // Monitor: pops expected SRAM accesses and acks as the DUTs present them.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (sram_we[i]) chk("we_needs_cs", i, 32'(sram_cs[i]), 32'd1);
                if (sram_cs[i]) begin
                    if (acc_q.size() == 0) begin
                        chk("unexpected_access", i, 32'd1, 32'd0);
                    end else begin
                        acc_t a;
                        a = acc_q.pop_front();
                        chk("acc_inst", i, 32'(i), 32'(a.inst));
                        chk("acc_cycle", i, 32'(cyc), 32'(a.cyc));
                        chk("acc_we", i, 32'(sram_we[i]), 32'(a.we));
                        chk("acc_addr", i, 32'(sram_addr[i]), 32'(a.addr));
                        chk("acc_busy", i, 32'(busy[i]), 32'd1);
                        if (a.we) chk("acc_wdata", i, 32'(sram_wdata[i]), 32'(a.wdata));
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    if ((p == 1) ? ld_ack[i] : cpu_ack[i]) begin
                        if (ack_q.size() == 0) begin
                            chk(p == 1 ? "unexpected_ld_ack" : "unexpected_cpu_ack", i, 32'd1, 32'd0);
                        end else begin
                            ack_t e;
                            e = ack_q.pop_front();
                            chk("ack_inst", i, 32'(i), 32'(e.inst));
                            chk("ack_port_ld", i, 32'(p), 32'(e.ld));
                            chk("ack_cycle", i, 32'(cyc), 32'(e.cyc));
                            chk("gnt_ld_at_ack", i, 32'(gnt_ld[i]), 32'(e.ld));
                            if (e.rd)
                                chk("ack_rdata", i, 32'((p == 1) ? ld_rdata[i] : cpu_rdata[i]), 32'(e.data));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1);
    end

    initial begin
        int s;
        cpu_req = '0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
        ld_req  = '0; ld_we  = '0; ld_addr  = '0; ld_wdata  = '0;
        sys_rst_n = 1'b0;

        // Reset values on every instance.
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_cpu_ack", i, 32'(cpu_ack[i]), 32'd0);
            chk("rst_ld_ack", i, 32'(ld_ack[i]), 32'd0);
            chk("rst_busy", i, 32'(busy[i]), 32'd0);
            chk("rst_sram_cs", i, 32'(sram_cs[i]), 32'd0);
            chk("rst_sram_we", i, 32'(sram_we[i]), 32'd0);
            chk("rst_sram_addr", i, 32'(sram_addr[i]), 32'd0);
            chk("rst_sram_wdata", i, 32'(sram_wdata[i]), 32'd0);
            chk("rst_cpu_rdata", i, 32'(cpu_rdata[i]), 32'd0);
            chk("rst_ld_rdata", i, 32'(ld_rdata[i]), 32'd0);
            chk("rst_gnt_ld", i, 32'(gnt_ld[i]), 32'd1);
        end
        sys_rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_busy", 0, 32'(busy[0]), 32'd0);
        end

        // CPU write then read back, RD_LAT=2.
        txn(0, 1'b0, 1'b1, 15'h1234, 8'hA5, 8'h00);
        txn(0, 1'b0, 1'b0, 15'h1234, 8'h00, 8'hA5);

        // Fixed priority tie: CPU three back-to-back writes, loader waits.
        @(negedge clk);
        s = cyc;
        exp_acc(0, 1'b1, 15'h0010, 8'h11, s + 1);  exp_ack(0, 1'b0, 1'b0, 8'h00, s + 2);
        exp_acc(0, 1'b1, 15'h0011, 8'h22, s + 4);  exp_ack(0, 1'b0, 1'b0, 8'h00, s + 5);
        exp_acc(0, 1'b1, 15'h0012, 8'h33, s + 7);  exp_ack(0, 1'b0, 1'b0, 8'h00, s + 8);
        exp_acc(0, 1'b1, 15'h0100, 8'h3C, s + 10); exp_ack(0, 1'b1, 1'b0, 8'h00, s + 11);
        fork
            begin
                drive(0, 1'b0, 1'b1, 15'h0010, 8'h11);
                drive(0, 1'b0, 1'b1, 15'h0011, 8'h22);
                drive(0, 1'b0, 1'b1, 15'h0012, 8'h33);
                rel(0, 1'b0);
            end
            begin
                drive(0, 1'b1, 1'b1, 15'h0100, 8'h3C);
                rel(0, 1'b1);
            end
        join
        txn(0, 1'b1, 1'b0, 15'h0100, 8'h00, 8'h3C);

        // Round-robin tie: CPU, LD, CPU, LD with both held.
        @(negedge clk);
        s = cyc;
        exp_acc(1, 1'b1, 15'h0200, 8'h5A, s + 1);  exp_ack(1, 1'b0, 1'b0, 8'h00, s + 2);
        exp_acc(1, 1'b1, 15'h0300, 8'hC3, s + 4);  exp_ack(1, 1'b1, 1'b0, 8'h00, s + 5);
        exp_acc(1, 1'b0, 15'h0300, 8'h00, s + 7);  exp_ack(1, 1'b0, 1'b1, 8'hC3, s + 10);
        exp_acc(1, 1'b0, 15'h0200, 8'h00, s + 12); exp_ack(1, 1'b1, 1'b1, 8'h5A, s + 15);
        fork
            begin
                drive(1, 1'b0, 1'b1, 15'h0200, 8'h5A);
                drive(1, 1'b0, 1'b0, 15'h0300, 8'h00);
                rel(1, 1'b0);
            end
            begin
                drive(1, 1'b1, 1'b1, 15'h0300, 8'hC3);
                drive(1, 1'b1, 1'b0, 15'h0200, 8'h00);
                rel(1, 1'b1);
            end
        join

        // Latency extremes: RD_LAT=1 and RD_LAT=7, top address on the loader.
        txn(2, 1'b0, 1'b1, 15'h0042, 8'h99, 8'h00);
        txn(2, 1'b0, 1'b0, 15'h0042, 8'h00, 8'h99);
        txn(3, 1'b1, 1'b1, 15'h7FFF, 8'h6E, 8'h00);
        txn(3, 1'b1, 1'b0, 15'h7FFF, 8'h00, 8'h6E);

        // Reset during WAIT of a loader read: no ack, outputs cleared at once.
        @(negedge clk);
        s = cyc;
        exp_acc(3, 1'b0, 15'h7FFF, 8'h00, s + 1);
        ld_req[3] = 1'b1; ld_we[3] = 1'b0; ld_addr[3] = 15'h7FFF;
        repeat (4) @(negedge clk);
        chk("wait_busy", 3, 32'(busy[3]), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_busy", 3, 32'(busy[3]), 32'd0);
        chk("midrst_sram_cs", 3, 32'(sram_cs[3]), 32'd0);
        chk("midrst_ld_ack", 3, 32'(ld_ack[3]), 32'd0);
        chk("midrst_ld_rdata", 3, 32'(ld_rdata[3]), 32'd0);
        chk("midrst_sram_addr", 3, 32'(sram_addr[3]), 32'd0);
        chk("midrst_gnt_ld", 3, 32'(gnt_ld[3]), 32'd1);
        ld_req[3] = 1'b0;
        repeat (2) @(negedge clk);
        sys_rst_n = 1'b1;
        repeat (12) @(negedge clk);
        txn(3, 1'b0, 1'b0, 15'h7FFF, 8'h00, 8'h6E);

        repeat (5) @(negedge clk);
        chk("ack_q_drained", 0, 32'(ack_q.size()), 32'd0);
        chk("acc_q_drained", 0, 32'(acc_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port access sequencer for the 32Kx8 on-chip SRAM: it lets the 6502 CPU bus and a second master (the serial program loader) share one SRAM port. It arbitrates between requests, drives the SRAM control/address/data lines for exactly one access at a time, waits out the SRAM read latency, and returns data plus a one-cycle acknowledge to the winning requester. It sits between `mem_map`/CPU data mux and the SRAM macro, in the SRAM clock domain.

## Interface
- `ADDR_W`, 15, SRAM address width (32K).
- `DATA_W`, 8, data width.
- `RD_LAT`, 2, cycles from the `sram_cs` cycle to valid `sram_rdata`; legal range 1..7.
- `CPU_PRIO`, 1, 1 = CPU always wins a tie; 0 = round-robin on tie.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: CPU access request, level, held until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read; stable while `cpu_req`.
- `cpu_addr` in ADDR_W: CPU address; stable while `cpu_req`.
- `cpu_wdata` in DATA_W: CPU write data; stable while `cpu_req`.
- `cpu_rdata` out DATA_W: registered read data, valid when `cpu_ack`.
- `cpu_ack` out 1: one-cycle completion pulse.
- `ld_req`, `ld_we`, `ld_addr`, `ld_wdata`, `ld_rdata`, `ld_ack`: loader port, identical semantics.
- `sram_cs` out 1: SRAM select, active high.
- `sram_we` out 1: SRAM write enable, active high, only ever high with `sram_cs`.
- `sram_addr` out ADDR_W: SRAM address.
- `sram_wdata` out DATA_W: SRAM write data.
- `sram_rdata` in DATA_W: SRAM read data.
- `busy` out 1: high in every state except IDLE.
- `gnt_ld` out 1: 1 while the current or last transaction belongs to the loader.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it and go to ACCESS.
  - Both requests: if `CPU_PRIO`=1, grant CPU. Otherwise grant the port not granted last (`gnt_ld` inverted).
  - Latch the winner's we/addr/wdata into the SRAM output registers.
- ACCESS: `sram_cs`=1 and `sram_we`=latched we, for exactly one cycle.
  - Write: go to DONE.
  - Read: go to WAIT with a latency counter loaded to RD_LAT-1.
- WAIT: `sram_cs`=0. The counter decrements each cycle. When it reaches 0, capture `sram_rdata` into the granted port's rdata register and go to DONE.
  - RD_LAT=1 means WAIT lasts exactly one cycle.
- DONE: the granted port's ack=1 for one cycle, then return to IDLE.
- The other port's rdata register holds its previous value.
- `gnt_ld` updates on grant. Reset value 1, so the first round-robin tie goes to the CPU.
- Addresses pass through unmodified: no wrap logic and no arithmetic.
- Requester rule: deassert req, or present the next request, at the same edge that samples ack=1. IDLE then samples the fresh value.
  - If the arbiter sees req still high in IDLE, it takes that as a new request.
- A req that drops before ack is a protocol violation. The arbiter still completes the transaction and pulses ack.
- Reset (asynchronous, any state, including mid-WAIT):
  - Go to IDLE immediately.
  - `sram_cs`/`sram_we`/`cpu_ack`/`ld_ack`/`busy` = 0.
  - `sram_addr`/`sram_wdata`/`cpu_rdata`/`ld_rdata` = 0; `gnt_ld` = 1.
  - The in-flight transaction is dropped and no ack is issued.

## Timing
- Request first seen high at edge of cycle 0 (IDLE) → cycle 1 ACCESS (`sram_cs`=1).
- Write: `ack` high in cycle 2. Back in IDLE cycle 3. Next grant earliest ACCESS in cycle 4, so a write occupies 3 cycles.
- Read: `sram_rdata` sampled at end of cycle 1+RD_LAT. `rdata`/`ack` valid in cycle 2+RD_LAT. IDLE in cycle 3+RD_LAT. A read occupies RD_LAT+3 cycles (5 for default).
- Loser of a tie keeps req high. It is granted in the IDLE following the winner's DONE, unless `CPU_PRIO`=1 and the CPU requests again.
- `busy` rises in cycle 1 and falls in the IDLE cycle after DONE.

## Test plan
- **Reset values:** assert `sys_rst_n`=0 → every output at its reset value, `gnt_ld`=1; release with no req → `busy` stays 0.
- **CPU write then read:** CPU write addr 0x1234 data 0xA5, then read 0x1234.
  - Write: `sram_cs`/`sram_we` high only in cycle 1, `cpu_ack` in cycle 2.
  - Read: `cpu_rdata`=0xA5 with `cpu_ack` in cycle 4 after its IDLE (RD_LAT=2).
- **Tie, fixed priority:** `CPU_PRIO`=1, both req high in the same cycle, CPU repeats back-to-back 3 times → 3 CPU acks, 0 loader acks; loader completes once the CPU drops req.
- **Tie, round-robin:** `CPU_PRIO`=0, both req held continuously → grants alternate CPU, LD, CPU, LD starting with CPU; `gnt_ld` toggles per transaction.
- **RD_LAT sweep:** run with `RD_LAT`=1 and 7 → read ack at cycles 3 and 9 after the request cycle; loader write to 0x7FFF then read → `sram_addr`=0x7FFF, data intact.
- **Reset mid-operation:** drop `sys_rst_n` during WAIT of a loader read → outputs cleared that cycle, no `ld_ack` ever; after release a new CPU read completes normally.
